// File: rtl/data_ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_ctrl_pkg
// Brief    : Shared access-size encodings, FSM state codes and request record
//            for the data RAM controller and its lane unit.
// Revision : 1.0 - initial release
// ============================================================================
package data_ram_ctrl_pkg;

    localparam logic [1:0] c_sz_byte = 2'b00;
    localparam logic [1:0] c_sz_half = 2'b01;
    localparam logic [1:0] c_sz_word = 2'b10;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_rd   = 3'd1;
    localparam logic [2:0] c_st_data = 3'd2;
    localparam logic [2:0] c_st_wr   = 3'd3;
    localparam logic [2:0] c_st_resp = 3'd4;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Bad size, misaligned half/word, or byte address beyond the RAM.
    function automatic logic req_error(input logic [1:0] size, input logic [31:0] addr,
                                       input int addr_w);
        logic bad;
        case (size)
            c_sz_byte: bad = 1'b0;
            c_sz_half: bad = addr[0];
            c_sz_word: bad = |addr[1:0];
            default:   bad = 1'b1;
        endcase
        return bad || ((addr >> (addr_w + 2)) != 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_ram_ctrl_lane.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_ctrl_lane
// Brief    : Combinational lane unit: little-endian load extract/extend and
//            sub-word store merge into a full 32-bit word.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_ctrl_lane
    import data_ram_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (lane)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        w_half = lane[1] ? word[31:16] : word[15:0];

        load_data  = word;
        merge_data = word;
        case (size)
            c_sz_byte: begin
                load_data = {{24{sgn & w_byte[7]}}, w_byte};
                case (lane)
                    2'd0:    merge_data[7:0]   = wdata[7:0];
                    2'd1:    merge_data[15:8]  = wdata[7:0];
                    2'd2:    merge_data[23:16] = wdata[7:0];
                    default: merge_data[31:24] = wdata[7:0];
                endcase
            end
            c_sz_half: begin
                load_data = {{16{sgn & w_half[15]}}, w_half};
                if (lane[1]) begin
                    merge_data[31:16] = wdata[15:0];
                end else begin
                    merge_data[15:0] = wdata[15:0];
                end
            end
            default: begin
                load_data  = word;
                merge_data = wdata;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_ctrl
// Brief    : Two-port round-robin sequencer for the single-port data RAM with
//            sub-word read-modify-write, load extension and error flagging.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_we,
    input  logic [3:0]        req_size,
    input  logic [1:0]        req_signed,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    output logic [1:0]        req_gnt,
    output logic [1:0]        rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    logic [2:0]        r_state;
    logic              r_dispatch;
    logic              r_rr_last;
    req_t              r_req;
    logic [1:0]        r_gnt;
    logic [1:0]        r_rsp_valid;
    logic              r_rsp_err;
    logic [31:0]       r_rsp_rdata;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [31:0]       r_ram_wdata;

    logic              w_win;
    req_t              w_sel;
    logic              w_err;
    logic [31:0]       w_load;
    logic [31:0]       w_merge;

    always_comb begin
        w_win       = (req_valid == 2'b11) ? ~r_rr_last : req_valid[1];
        w_sel.port  = w_win;
        w_sel.we    = w_win ? req_we[1]          : req_we[0];
        w_sel.size  = w_win ? req_size[3:2]      : req_size[1:0];
        w_sel.sgn   = w_win ? req_signed[1]      : req_signed[0];
        w_sel.addr  = w_win ? req_addr[63:32]    : req_addr[31:0];
        w_sel.wdata = w_win ? req_wdata[63:32]   : req_wdata[31:0];
    end

    assign w_err = req_error(r_req.size, r_req.addr, ADDR_W);

    data_ram_ctrl_lane u_lane (
        .word       (ram_rdata),
        .lane       (r_req.addr[1:0]),
        .size       (r_req.size),
        .sgn        (r_req.sgn),
        .wdata      (r_req.wdata),
        .load_data  (w_load),
        .merge_data (w_merge)
    );

    // IDLE spends the grant cycle decoding the latched request before dispatching.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_dispatch  <= 1'b0;
            r_rr_last   <= 1'b1;
            r_req       <= '0;
            r_gnt       <= 2'b00;
            r_rsp_valid <= 2'b00;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= 32'd0;
        end else begin
            r_gnt       <= 2'b00;
            r_rsp_valid <= 2'b00;
            r_rsp_err   <= 1'b0;
            r_ram_we    <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (r_dispatch) begin
                        r_dispatch <= 1'b0;
                        if (w_err) begin
                            r_state <= c_st_resp;
                        end else if (r_req.we && (r_req.size == c_sz_word)) begin
                            r_ram_addr  <= r_req.addr[ADDR_W+1:2];
                            r_ram_wdata <= r_req.wdata;
                            r_state     <= c_st_wr;
                        end else begin
                            r_ram_addr <= r_req.addr[ADDR_W+1:2];
                            r_state    <= c_st_rd;
                        end
                    end else if (|req_valid) begin
                        r_gnt      <= w_win ? 2'b10 : 2'b01;
                        r_rr_last  <= w_win;
                        r_req      <= w_sel;
                        r_dispatch <= 1'b1;
                    end
                end
                c_st_rd: begin
                    r_state <= c_st_data;
                end
                c_st_data: begin
                    if (r_req.we) begin
                        r_ram_wdata <= w_merge;
                        r_state     <= c_st_wr;
                    end else begin
                        r_rsp_rdata <= w_load;
                        r_state     <= c_st_resp;
                    end
                end
                c_st_wr: begin
                    r_ram_we <= 1'b1;
                    r_state  <= c_st_resp;
                end
                c_st_resp: begin
                    r_rsp_valid <= r_req.port ? 2'b10 : 2'b01;
                    r_rsp_err   <= w_err;
                    r_state     <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign req_gnt   = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;
    assign ram_wdata = r_ram_wdata;

endmodule
`default_nettype wire
